// File: rtl/maroc_sc_pkg.sv
// maroc_sc_pkg: frame width, field offsets/widths and FSM state for the MAROC slow-control transmitter
package maroc_sc_pkg;
  localparam int FRAME_W = 829;
  localparam int IDX_W = 10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);
  localparam int OFF_BIAS = 0, W_BIAS = 3;
  localparam int OFF_DAC2 = 3, OFF_DAC1 = 13, W_DAC = 10;
  localparam int OFF_ADC = 23, W_ADC = 4;
  localparam int OFF_MASK = 27, W_MASK = 128;
  localparam int OFF_GLB = 155, W_GLB = 34;
  localparam int OFF_GAIN = 189, W_GAIN = 576;
  localparam int OFF_CTEST = 765, W_CTEST = 64;
  typedef enum logic [1:0] {LOAD, SHIFT, DONE} sc_state_t;
endpackage

// File: rtl/sc_frame_pack.sv
// sc_frame_pack: packs the slow-control ports into the 829-bit frame, LSB of each field at its lowest index
// Ports: bias/DAC enables, DAC2/DAC1 codes, ADC controls, mask_OR_ch, 34 global scalars, GAIN, Ctest_ch in; frame out.
module sc_frame_pack import maroc_sc_pkg::*; (
  input  logic                 ON_OFF_otabg, ON_OFF_dac, small_dac,
  input  logic [W_DAC-1:0]     DAC2, DAC1,
  input  logic                 enb_outADC, inv_startCmptGray, ramp_8bit, ramp_10bit,
  input  logic [W_MASK-1:0]    mask_OR_ch,
  input  logic                 cmd_CK_mux, d1_d2, inv_discriADC, polar_discri, Enb_tristate,
  input  logic                 valid_dc_fsb2, sw_fsb2_50f, sw_fsb2_100f, sw_fsb2_100k, sw_fsb2_50k,
  input  logic                 valid_dc_fs, cmd_fsb_fsu, sw_fsb1_50f, sw_fsb1_100f, sw_fsb1_100k, sw_fsb1_50k,
  input  logic                 sw_fsu_100k, sw_fsu_50k, sw_fsu_25k, sw_fsu_40f, sw_fsu_20f,
  input  logic                 H1H2_choice, EN_ADC, sw_ss_1200f, sw_ss_600f, sw_ss_300f, ON_OFF_ss,
  input  logic                 swb_buf_2p, swb_buf_1p, swb_buf_500f, swb_buf_250f,
  input  logic                 cmd_fsb, cmd_ss, cmd_fsu,
  input  logic [W_GAIN-1:0]    GAIN,
  input  logic [W_CTEST-1:0]   Ctest_ch,
  output logic [FRAME_W-1:0]   frame
);
  assign frame[OFF_BIAS +: W_BIAS] = {small_dac, ON_OFF_dac, ON_OFF_otabg};
  assign frame[OFF_DAC2 +: W_DAC] = DAC2;
  assign frame[OFF_DAC1 +: W_DAC] = DAC1;
  assign frame[OFF_ADC +: W_ADC] = {ramp_10bit, ramp_8bit, inv_startCmptGray, enb_outADC};
  assign frame[OFF_MASK +: W_MASK] = mask_OR_ch;
  assign frame[OFF_GLB +: W_GLB] = {
    cmd_fsu, cmd_ss, cmd_fsb,
    swb_buf_250f, swb_buf_500f, swb_buf_1p, swb_buf_2p,
    ON_OFF_ss, sw_ss_300f, sw_ss_600f, sw_ss_1200f, EN_ADC, H1H2_choice,
    sw_fsu_20f, sw_fsu_40f, sw_fsu_25k, sw_fsu_50k, sw_fsu_100k,
    sw_fsb1_50k, sw_fsb1_100k, sw_fsb1_100f, sw_fsb1_50f, cmd_fsb_fsu, valid_dc_fs,
    sw_fsb2_50k, sw_fsb2_100k, sw_fsb2_100f, sw_fsb2_50f, valid_dc_fsb2,
    Enb_tristate, polar_discri, inv_discriADC, d1_d2, cmd_CK_mux};
  assign frame[OFF_GAIN +: W_GAIN] = GAIN;
  assign frame[OFF_CTEST +: W_CTEST] = Ctest_ch;
endmodule

// File: rtl/transmitter.sv
// transmitter: latches the MAROC slow-control frame and shifts it out LSB-first on D_SC
// Ports: CK_SC clock; set_new_data sync active-high reset / load command; slow-control fields in; D_SC serial out.
// SC_AUTO_REPEAT_EN: when defined the latched frame is retransmitted continuously instead of stopping in DONE.
module transmitter import maroc_sc_pkg::*; (
  input  logic                 CK_SC,
  input  logic                 set_new_data,
  input  logic                 ON_OFF_otabg, ON_OFF_dac, small_dac,
  input  logic [W_DAC-1:0]     DAC2, DAC1,
  input  logic                 enb_outADC, inv_startCmptGray, ramp_8bit, ramp_10bit,
  input  logic [W_MASK-1:0]    mask_OR_ch,
  input  logic                 cmd_CK_mux, d1_d2, inv_discriADC, polar_discri, Enb_tristate,
  input  logic                 valid_dc_fsb2, sw_fsb2_50f, sw_fsb2_100f, sw_fsb2_100k, sw_fsb2_50k,
  input  logic                 valid_dc_fs, cmd_fsb_fsu, sw_fsb1_50f, sw_fsb1_100f, sw_fsb1_100k, sw_fsb1_50k,
  input  logic                 sw_fsu_100k, sw_fsu_50k, sw_fsu_25k, sw_fsu_40f, sw_fsu_20f,
  input  logic                 H1H2_choice, EN_ADC, sw_ss_1200f, sw_ss_600f, sw_ss_300f, ON_OFF_ss,
  input  logic                 swb_buf_2p, swb_buf_1p, swb_buf_500f, swb_buf_250f,
  input  logic                 cmd_fsb, cmd_ss, cmd_fsu,
  input  logic [W_GAIN-1:0]    GAIN,
  input  logic [W_CTEST-1:0]   Ctest_ch,
  output logic                 D_SC
);
  logic [FRAME_W-1:0] frame_in, frame;
  logic [IDX_W-1:0] idx, idx_n;
  logic last, d_n;
  sc_state_t state, state_n;
  sc_frame_pack u_pack (.*, .frame(frame_in));
  assign last = idx == LAST_IDX;
  always_ff @(posedge CK_SC) begin
    if (set_new_data) begin
      frame <= frame_in;
      idx <= '0;
      D_SC <= 1'b0;
      state <= LOAD;
    end else begin
      idx <= idx_n;
      D_SC <= d_n;
      state <= state_n;
    end
  end
  // LOAD behaves as the first SHIFT cycle, so F[0] leaves on the edge after set_new_data falls
  always_comb begin
    d_n = state == DONE ? 1'b0 : frame[idx];
`ifdef SC_AUTO_REPEAT_EN
    state_n = SHIFT;
    idx_n = last ? '0 : idx + IDX_W'(1);
`else
    state_n = (state == DONE || last) ? DONE : SHIFT;
    idx_n = (state == DONE || last) ? idx : idx + IDX_W'(1);
`endif
  end
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: scoreboard bench; the driver queues the expected D_SC per edge, a negedge monitor pops and compares
module tb_transmitter;
  logic CK_SC = 1'b0;
  logic set_new_data;
  logic D_SC;
  logic [828:0] stim, exp_f;
  logic q[$];
  logic stim_done = 1'b0;
  int n_chk = 0, n_fail = 0;

  always #5 CK_SC = ~CK_SC;

  transmitter dut (
    .CK_SC(CK_SC), .set_new_data(set_new_data), .D_SC(D_SC),
    .ON_OFF_otabg(stim[0]), .ON_OFF_dac(stim[1]), .small_dac(stim[2]),
    .DAC2(stim[12:3]), .DAC1(stim[22:13]),
    .enb_outADC(stim[23]), .inv_startCmptGray(stim[24]), .ramp_8bit(stim[25]), .ramp_10bit(stim[26]),
    .mask_OR_ch(stim[154:27]),
    .cmd_CK_mux(stim[155]), .d1_d2(stim[156]), .inv_discriADC(stim[157]), .polar_discri(stim[158]),
    .Enb_tristate(stim[159]),
    .valid_dc_fsb2(stim[160]), .sw_fsb2_50f(stim[161]), .sw_fsb2_100f(stim[162]), .sw_fsb2_100k(stim[163]),
    .sw_fsb2_50k(stim[164]),
    .valid_dc_fs(stim[165]), .cmd_fsb_fsu(stim[166]), .sw_fsb1_50f(stim[167]), .sw_fsb1_100f(stim[168]),
    .sw_fsb1_100k(stim[169]), .sw_fsb1_50k(stim[170]),
    .sw_fsu_100k(stim[171]), .sw_fsu_50k(stim[172]), .sw_fsu_25k(stim[173]), .sw_fsu_40f(stim[174]),
    .sw_fsu_20f(stim[175]),
    .H1H2_choice(stim[176]), .EN_ADC(stim[177]), .sw_ss_1200f(stim[178]), .sw_ss_600f(stim[179]),
    .sw_ss_300f(stim[180]), .ON_OFF_ss(stim[181]),
    .swb_buf_2p(stim[182]), .swb_buf_1p(stim[183]), .swb_buf_500f(stim[184]), .swb_buf_250f(stim[185]),
    .cmd_fsb(stim[186]), .cmd_ss(stim[187]), .cmd_fsu(stim[188]),
    .GAIN(stim[764:189]), .Ctest_ch(stim[828:765])
  );

  function automatic logic [828:0] rnd();
    logic [828:0] r;
    for (int i = 0; i < 829; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  task automatic cyc(input logic snd, input logic e);
    set_new_data = snd;
    @(posedge CK_SC);
    q.push_back(e);
    #1;
  endtask

  task automatic shift(input int s, input int n);
    for (int k = s; k < s + n; k++) cyc(1'b0, exp_f[k]);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  task automatic tail(input int n);
`ifdef SC_AUTO_REPEAT_EN
    shift(0, n);
`else
    idle(n);
`endif
  endtask

  initial begin
    set_new_data = 1'b1;
    stim = rnd();
    stim[828:765] = 64'd1;
    exp_f = stim;
    cyc(1'b1, 1'b0);
    n_chk++;
    if (D_SC !== 1'b0) begin
      n_fail++;
      $display("FAIL load check: D_SC=%b after set_new_data edge, expected 0", D_SC);
    end
    shift(0, 829);
`ifdef SC_AUTO_REPEAT_EN
    shift(0, 829);
`else
    idle(20);
`endif
    stim = '0;
    stim[22:13] = 10'h3FF;
    exp_f = stim;
    cyc(1'b1, 1'b0);
    shift(0, 829);
    tail(5);
    stim = rnd();
    exp_f = stim;
    cyc(1'b1, 1'b0);
    shift(0, 300);
    stim = rnd();
    shift(300, 529);
    tail(3);
    stim = rnd();
    exp_f = stim;
    cyc(1'b1, 1'b0);
    shift(0, 400);
    stim = rnd();
    exp_f = stim;
    cyc(1'b1, 1'b0);
    n_chk++;
    if (D_SC !== 1'b0) begin
      n_fail++;
      $display("FAIL abort check: D_SC=%b after mid-frame reload, expected 0", D_SC);
    end
    shift(0, 829);
    tail(10);
    stim_done = 1'b1;
  end

  initial begin
    logic e;
    forever begin
      @(negedge CK_SC);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (D_SC !== e) begin
          n_fail++;
          $display("FAIL d_sc check #%0d: got %b expected %b", n_chk, D_SC, e);
        end
      end else if (stim_done) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 20000 cycles");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 CK_SC  input  1  serial clock; all state updates on its rising edge.
REQ-002 set_new_data  input  1  reset, synchronous, active-high; doubles as the "load new frame" command.
REQ-003 D_SC  output  1  serial slow-control data to the MAROC chip.
REQ-004 ON_OFF_otabg, ON_OFF_dac, small_dac  input  1 each  bias/DAC enables.
REQ-005 DAC2, DAC1  input  10 each  threshold DAC codes.
REQ-006 enb_outADC, inv_startCmptGray, ramp_8bit, ramp_10bit  input  1 each  ADC controls.
REQ-007 mask_OR_ch  input  128  OR1/OR2 channel masks.
REQ-008 34 global scalar inputs, 1 bit each, in frame order:
- cmd_CK_mux, d1_d2, inv_discriADC, polar_discri, Enb_tristate
- valid_dc_fsb2, sw_fsb2_50f, sw_fsb2_100f, sw_fsb2_100k, sw_fsb2_50k
- valid_dc_fs, cmd_fsb_fsu, sw_fsb1_50f, sw_fsb1_100f, sw_fsb1_100k, sw_fsb1_50k
- sw_fsu_100k, sw_fsu_50k, sw_fsu_25k, sw_fsu_40f, sw_fsu_20f
- H1H2_choice, EN_ADC, sw_ss_1200f, sw_ss_600f, sw_ss_300f, ON_OFF_ss
- swb_buf_2p, swb_buf_1p, swb_buf_500f, swb_buf_250f
- cmd_fsb, cmd_ss, cmd_fsu
REQ-009 GAIN  input  576  per-channel gain bits (8 x 64) plus cmd_SUM (64).
REQ-010 Ctest_ch  input  64  test-capacitor enables.

Function
REQ-011 Frame is 829 bits, F[828:0]:
- F[0]=ON_OFF_otabg, F[1]=ON_OFF_dac, F[2]=small_dac
- F[12:3]=DAC2, F[22:13]=DAC1
- F[23]=enb_outADC, F[24]=inv_startCmptGray, F[25]=ramp_8bit, F[26]=ramp_10bit
- F[154:27]=mask_OR_ch
- F[188:155]=the 34 REQ-008 bits, in the listed order (cmd_CK_mux at 155, cmd_fsu at 188)
- F[764:189]=GAIN, F[828:765]=Ctest_ch
- each vector maps LSB to the lowest frame index.
REQ-012 States:
- LOAD: set_new_data high.
- SHIFT: bit index 0..828.
- DONE.
REQ-013 Rising edge with set_new_data=1: capture all inputs into an 829-bit frame register, set bit index 0, force D_SC=0.
REQ-014 In SHIFT, each rising edge drives D_SC=F[index] (registered output) and then increments the index. F[0] appears on the first edge after set_new_data falls, and F[k] on the (k+1)-th edge.
REQ-015 D_SC is stable for a full CK_SC period, so the receiver samples it on the falling edge.
REQ-016 Transmission is LSB-first; F[828] is the last bit.
REQ-017 After F[828] has been driven for one cycle: next edge enters DONE with D_SC=0. DONE holds until set_new_data is asserted.
REQ-018 Input changes outside a set_new_data cycle do not affect the latched frame.
REQ-019 set_new_data asserted mid-frame aborts the current frame, reloads, and restarts at F[0]. No partial-frame completion.
REQ-020 Index counter is 10 bits and never exceeds 828.

Reset
REQ-021 Reset is synchronous and active-high on set_new_data; clock is CK_SC.
REQ-022 Reset values: D_SC=0, index=0, state SHIFT-pending, frame register = current inputs.
REQ-023 Before the first reset the output is don't-care; the bench asserts set_new_data at time 0.

Configuration
REQ-024 Macro SC_AUTO_REPEAT_EN:
- Defined: after F[828] the next edge drives F[0] of the same latched frame and retransmits continuously; DONE is unreachable.
- Undefined: behaviour per REQ-017.

Structure
REQ-025 Shared package maroc_sc_pkg holds FRAME_W=829, field offset/width constants per REQ-011, and the state enum.
REQ-026 One sub-module, sc_frame_pack: combinational concatenation of the ports into the 829-bit frame. transmitter holds the register, counter and FSM.

Verification
REQ-027 Pulse set_new_data with Ctest_ch=1 and other fields random; collect D_SC on 829 falling edges -> reassembled word equals F, with F[765]=1 and F[828:766]=0.
REQ-028 Set all inputs 0 except DAC1=10'h3FF -> ones exactly on falling edges 14..23 (1-based count), zeros elsewhere.
REQ-029 Complete a frame, then hold 20 further cycles -> D_SC=0 throughout (macro undefined).
REQ-030 Pulse set_new_data at bit 400 with new inputs -> D_SC=0 for one cycle, then the new frame streams from F[0].
REQ-031 Change inputs mid-frame without set_new_data -> transmitted frame matches the originally latched values.
REQ-032 With SC_AUTO_REPEAT_EN defined -> bit 829 equals F[0]; two consecutive frames are identical.
